bypass_net: RTL

- Parametrised register-forwarding network between the register-read stage and all in-flight result stages.
- Compares NUM_RPORTS read addresses against NUM_STAGES write-back candidates and selects the youngest matching value.
- Aligns load data at the data-return stage, holding it across back-end stalls, and raises a load-use stall request.
- Registers select/data per read port into the execute stage, with bubble insertion on decode-stall.

---
 rtl/bypass_net_pkg.sv | 26 ++
 rtl/bypass_net_load_align.sv | 58 +++++
 rtl/bypass_net.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bypass_net_pkg.sv
// Shared definitions for the register-forwarding network and the load aligner.
// Provides the default data and address widths, the stall-vector bit positions
// and their polarity, and the bit order of the one-hot load-op vector.
package bypass_net_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned AW_DEF = 5;

    // Stall vector bit positions: decode/read stage and load-return stage
    localparam int unsigned STALL_ID_BIT   = 3;
    localparam int unsigned STALL_HOLD_BIT = 7;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // One-hot load op, ordered as {lwl,lwr,lb,lbu,lh,lhu,lw}
    localparam int unsigned LD_OP_W = 7;
    localparam int unsigned LD_LW   = 0;
    localparam int unsigned LD_LHU  = 1;
    localparam int unsigned LD_LH   = 2;
    localparam int unsigned LD_LBU  = 3;
    localparam int unsigned LD_LB   = 4;
    localparam int unsigned LD_LWR  = 5;
    localparam int unsigned LD_LWL  = 6;

endpackage

// File: rtl/bypass_net_load_align.sv
// load_align: combinational alignment of a raw data-RAM word for a load.
// Also used by the mem stage, so it carries no state.
// Ports:
//   op_i      one-hot load op {lwl,lwr,lb,lbu,lh,lhu,lw}
//   offset_i  low two bits of the load address
//   rdata_i   raw data RAM word
//   reg2_i    current rt value, merged into lwl/lwr results
//   value_c   aligned, extended or merged load value
module bypass_net_load_align
    import bypass_net_pkg::*;
(
    input  logic [LD_OP_W-1:0] op_i,
    input  logic [1:0]         offset_i,
    input  logic [DW_DEF-1:0]  rdata_i,
    input  logic [DW_DEF-1:0]  reg2_i,
    output logic [DW_DEF-1:0]  value_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Byte and half-word selected by the address offset
    assign byte_c = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_c = rdata_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        value_c = '0;
        if (op_i[LD_LB]) begin
            value_c = {{(DW_DEF-8){byte_c[7]}}, byte_c};
        end else if (op_i[LD_LBU]) begin
            value_c = {{(DW_DEF-8){1'b0}}, byte_c};
        end else if (op_i[LD_LH]) begin
            // Misaligned half-word returns zero
            value_c = offset_i[0] ? '0 : {{(DW_DEF-16){half_c[15]}}, half_c};
        end else if (op_i[LD_LHU]) begin
            value_c = offset_i[0] ? '0 : {{(DW_DEF-16){1'b0}}, half_c};
        end else if (op_i[LD_LW]) begin
            value_c = rdata_i;
        end else if (op_i[LD_LWL]) begin
            // Little-endian lwl: low memory bytes fill the top of rt
            case (offset_i)
                2'd0:    value_c = {rdata_i[7:0],  reg2_i[23:0]};
                2'd1:    value_c = {rdata_i[15:0], reg2_i[15:0]};
                2'd2:    value_c = {rdata_i[23:0], reg2_i[7:0]};
                default: value_c = rdata_i;
            endcase
        end else if (op_i[LD_LWR]) begin
            // Little-endian lwr: high memory bytes fill the bottom of rt
            case (offset_i)
                2'd0:    value_c = rdata_i;
                2'd1:    value_c = {reg2_i[31:24], rdata_i[31:8]};
                2'd2:    value_c = {reg2_i[31:16], rdata_i[31:16]};
                default: value_c = {reg2_i[31:8],  rdata_i[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/bypass_net.sv
// bypass_net: register forwarding from all in-flight result stages to the
// register-read ports, with load-data alignment/hold at the data-return stage
// and a combinational load-use stall request.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              pipeline flush
//   stall              stall vector, 1 = Stop
//   stallreq_for_load  load-use stall request (combinational)
//   rf_raddr           read addresses, port p at [p*AW +: AW]
//   src_we/waddr/wdata per-source write-back candidates, index 0 youngest
//   src_is_load        source holds a load whose data is not yet available
//   ld_op, ld_rdata, ld_rdata_valid, ld_rt_raddr, ld_rt_rdata
//                      load-return stage instruction and RAM data
//   sel_fwd_r          registered forward-select per port
//   fwd_data_r         registered forwarded data per port
module bypass_net
    import bypass_net_pkg::*;
#(
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned LOAD_STAGE = 3,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned STALL_W    = 11,
    parameter int unsigned ID_BIT     = STALL_ID_BIT,
    parameter int unsigned HOLD_BIT   = STALL_HOLD_BIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [STALL_W-1:0]         stall,
    output logic                       stallreq_for_load,
    input  logic [NUM_RPORTS*AW-1:0]   rf_raddr,
    input  logic [NUM_STAGES-1:0]      src_we,
    input  logic [NUM_STAGES*AW-1:0]   src_waddr,
    input  logic [NUM_STAGES*DW-1:0]   src_wdata,
    input  logic [NUM_STAGES-1:0]      src_is_load,
    input  logic [LD_OP_W-1:0]         ld_op,
    input  logic [DW-1:0]              ld_rdata,
    input  logic                       ld_rdata_valid,
    input  logic [AW-1:0]              ld_rt_raddr,
    input  logic [DW-1:0]              ld_rt_rdata,
    output logic [NUM_RPORTS-1:0]      sel_fwd_r,
    output logic [NUM_RPORTS*DW-1:0]   fwd_data_r
);

    localparam int unsigned OLDEST = NUM_STAGES - 1;

    logic                     hold_flag_q, hold_flag_d;
    logic [DW-1:0]            hold_data_q, hold_data_d;
    logic [NUM_RPORTS-1:0]    sel_q, sel_d;
    logic [NUM_RPORTS*DW-1:0] data_q, data_d;

    logic [DW-1:0]            reg2_c, ld_live_c, ld_val_c;
    logic [NUM_RPORTS-1:0]    sel_c, req_c;
    logic [NUM_RPORTS*DW-1:0] data_c;

    // Stall bits outside the four used here are intentionally ignored
    logic unused_stall;
    assign unused_stall = ^stall;

    // rt for lwl/lwr: take the oldest in-flight result if it writes that register
    assign reg2_c = (src_we[OLDEST] && (src_waddr[OLDEST*AW +: AW] == ld_rt_raddr))
                  ? src_wdata[OLDEST*DW +: DW] : ld_rt_rdata;

    bypass_net_load_align u_load_align (
        .op_i     (ld_op),
        .offset_i (src_wdata[LOAD_STAGE*DW +: 2]),
        .rdata_i  (ld_rdata),
        .reg2_i   (reg2_c),
        .value_c  (ld_live_c)
    );

    assign ld_val_c = hold_flag_q ? hold_data_q : ld_live_c;

    // Per-port match; scanning oldest to youngest lets the youngest hit win
    always_comb begin
        sel_c  = '0;
        data_c = '0;
        req_c  = '0;
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
                if (src_we[s] &&
                    (src_waddr[s*AW +: AW] == rf_raddr[p*AW +: AW]) &&
                    (rf_raddr[p*AW +: AW] != '0)) begin
                    sel_c[p] = 1'b1;
                    if (s == int'(LOAD_STAGE)) begin
                        data_c[p*DW +: DW] = (ld_op != '0) ? ld_val_c : '0;
                        req_c[p] = (ld_op != '0) && !ld_rdata_valid && !hold_flag_q;
                    end else begin
                        data_c[p*DW +: DW] = src_wdata[s*DW +: DW];
                        req_c[p] = (s < int'(LOAD_STAGE)) && src_is_load[s];
                    end
                end
            end
        end
    end

    assign stallreq_for_load = |req_c;

    // Load hold: capture aligned data while the return stage and the next are stopped
    always_comb begin
        hold_flag_d = hold_flag_q;
        hold_data_d = hold_data_q;
        if (flush) begin
            hold_flag_d = 1'b0;
            hold_data_d = '0;
        end else if ((stall[HOLD_BIT] == NOSTOP) && hold_flag_q) begin
            hold_flag_d = 1'b0;
            hold_data_d = '0;
        end else if ((stall[HOLD_BIT] == STOP) && (stall[HOLD_BIT+1] == STOP) &&
                     !hold_flag_q && ld_rdata_valid) begin
            hold_flag_d = 1'b1;
            hold_data_d = ld_live_c;
        end
    end

    // Execute-stage registers: bubble when decode stops but execute proceeds
    always_comb begin
        sel_d  = sel_q;
        data_d = data_q;
        if (flush) begin
            sel_d  = '0;
            data_d = '0;
        end else if ((stall[ID_BIT] == STOP) && (stall[ID_BIT+1] == NOSTOP)) begin
            sel_d  = '0;
            data_d = '0;
        end else if (stall[ID_BIT] == NOSTOP) begin
            sel_d  = sel_c;
            data_d = data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_flag_q <= 1'b0;
            hold_data_q <= '0;
            sel_q       <= '0;
            data_q      <= '0;
        end else begin
            hold_flag_q <= hold_flag_d;
            hold_data_q <= hold_data_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
        end
    end

    assign sel_fwd_r  = sel_q;
    assign fwd_data_r = data_q;

endmodule
